// File: rtl/keypad_pkg.sv
// Shared keypad definitions: matrix geometry, scanner state encoding and the
// key codes that RowColEncoder produces from a row/column position.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } scanState_e;

  // Telephone layout: 1 2 3 / 4 5 6 / 7 8 9 / * 0 #
  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  function automatic logic [3:0] keyCode(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = KEY_0;
    case ({row, col})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = KEY_0;
      4'b11_10: code = KEY_HASH;
      default:  code = KEY_0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a bus of independent asynchronous level signals,
// with a configurable reset value so idle lines read as inactive.
module bit_sync #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: walks the rows, debounces press and release of
// the first key found and emits one keyValid strobe per physical press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_COLS-1:0] colIn,
  output logic [NUM_ROWS-1:0] rowDrive,
  output logic [1:0]          RowOut,
  output logic [1:0]          ColOut,
  output logic                keyValid,
  output logic                keyHeld
);

  localparam int MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  scanState_e          state, stateNext;
  logic [1:0]          row, rowNext, rowAdv;
  logic [1:0]          col, colNext, firstLow;
  logic [CW-1:0]       cnt, cntNext, cntInc;
  logic [NUM_COLS-1:0] colSync;
  logic                anyLow, colBit;

  bit_sync #(.WIDTH(NUM_COLS), .RESET_VALUE({NUM_COLS{1'b1}})) colSyncInst (
    .clk (clk),
    .rst (rst),
    .d   (colIn),
    .q   (colSync)
  );

  assign anyLow = ~&colSync;
  assign rowAdv = (row == 2'(NUM_ROWS - 1)) ? 2'd0 : row + 2'd1;
  assign cntInc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
  assign colBit = (col == 2'd0) ? colSync[0] : (col == 2'd1) ? colSync[1] : colSync[2];

  always_comb begin
    firstLow = 2'd2;
    if (!colSync[1]) firstLow = 2'd1;
    if (!colSync[0]) firstLow = 2'd0;
  end

  // One counter serves both row settling and press/release debouncing.
  always_comb begin
    stateNext = state;
    rowNext   = row;
    colNext   = col;
    cntNext   = cnt;
    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cntNext = '0;
          if (anyLow) begin
            colNext   = firstLow;
            stateNext = DEBOUNCE;
          end else begin
            rowNext = rowAdv;
          end
        end else begin
          cntNext = cntInc;
        end
      end
      DEBOUNCE: begin
        if (!colBit) begin
          if (cnt == DEB_LAST) begin
            stateNext = PRESSED;
            cntNext   = '0;
          end else begin
            cntNext = cntInc;
          end
        end else begin
          stateNext = SCAN;
          rowNext   = rowAdv;
          cntNext   = '0;
        end
      end
      PRESSED: begin
        stateNext = WAIT_RELEASE;
        cntNext   = '0;
      end
      WAIT_RELEASE: begin
        if (colBit) begin
          if (cnt == DEB_LAST) begin
            stateNext = SCAN;
            rowNext   = rowAdv;
            cntNext   = '0;
          end else begin
            cntNext = cntInc;
          end
        end else begin
          cntNext = '0;
        end
      end
      default: begin
        stateNext = SCAN;
        cntNext   = '0;
      end
    endcase
  end

  // Reported position is loaded on entry to PRESSED so it is valid with the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SCAN;
      row      <= 2'd0;
      col      <= 2'd0;
      cnt      <= '0;
      rowDrive <= 4'b1110;
      RowOut   <= 2'd0;
      ColOut   <= 2'd0;
    end else begin
      state    <= stateNext;
      row      <= rowNext;
      col      <= colNext;
      cnt      <= cntNext;
      rowDrive <= ~(4'b0001 << rowNext);
      if (stateNext == PRESSED) begin
        RowOut <= row;
        ColOut <= col;
      end
    end
  end

  assign keyValid = (state == PRESSED);
  assign keyHeld  = (state == PRESSED) || (state == WAIT_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives the column lines and a queue
// of expected key strobes is consumed as keyValid pulses appear.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic       clk;
  logic       rst;
  logic [2:0] colIn;
  logic [3:0] rowDrive;
  logic [1:0] RowOut;
  logic [1:0] ColOut;
  logic       keyValid;
  logic       keyHeld;

  logic [11:0] pressed;
  int total;
  int bad;

  typedef struct {
    logic [1:0] row;
    logic [1:0] col;
    logic [3:0] code;
  } expKey_t;

  expKey_t expQ[$];
  logic [3:0] codeTable [12];

  keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .colIn    (colIn),
    .rowDrive (rowDrive),
    .RowOut   (RowOut),
    .ColOut   (ColOut),
    .keyValid (keyValid),
    .keyHeld  (keyHeld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pressed key shorts its column low only while its row is driven low.
  always_comb begin
    colIn = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !rowDrive[r]) colIn[c] = 1'b0;
  end

  task automatic expectKey(input int r, input int c);
    expKey_t e;
    e.row  = 2'(r);
    e.col  = 2'(c);
    e.code = codeTable[r*3+c];
    expQ.push_back(e);
  endtask

  task automatic step(input int n);
    expKey_t e;
    repeat (n) begin
      @(negedge clk);
      if (keyValid === 1'b1) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL strobe_unexpected got row=%0d col=%0d, required no strobe", RowOut, ColOut);
        end else begin
          e = expQ.pop_front();
          if (RowOut !== e.row || ColOut !== e.col || keyHeld !== 1'b1 || keyCode(RowOut, ColOut) !== e.code) begin
            bad++;
            $display("[TB] FAIL strobe_value got row=%0d col=%0d held=%b code=%0d, required row=%0d col=%0d held=1 code=%0d",
                     RowOut, ColOut, keyHeld, keyCode(RowOut, ColOut), e.row, e.col, e.code);
          end
        end
      end
    end
  endtask

  task automatic checkDrained(input string name);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s missing strobes got %0d outstanding, required 0", name, expQ.size());
    end
    expQ.delete();
  endtask

  task automatic checkHeld(input string name, input logic want);
    total++;
    if (keyHeld !== want) begin
      bad++;
      $display("[TB] FAIL %s keyHeld got %b, required %b", name, keyHeld, want);
    end
  endtask

  task automatic test_reset;
    logic [3:0] expDrive;
    logic       quiet;
    rst = 1'b1;
    pressed = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++;
    if (rowDrive !== 4'b1110 || keyValid !== 1'b0 || keyHeld !== 1'b0 || RowOut !== 2'd0 || ColOut !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_state got drive=%b valid=%b held=%b row=%0d col=%0d, required 1110 0 0 0 0",
               rowDrive, keyValid, keyHeld, RowOut, ColOut);
    end
    quiet = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      expDrive = ~(4'b0001 << ((k / 4) % 4));
      total++;
      if (rowDrive !== expDrive) begin
        bad++;
        $display("[TB] FAIL row_cycle k=%0d got %b, required %b", k, rowDrive, expDrive);
      end
      if (keyValid !== 1'b0 || keyHeld !== 1'b0 || RowOut !== 2'd0 || ColOut !== 2'd0) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1) begin
      bad++;
      $display("[TB] FAIL idle_outputs got activity, required valid=held=0 row=col=0");
    end
  endtask

  task automatic test_press_release;
    pressed[1*3+1] = 1'b1;
    expectKey(1, 1);
    step(200);
    checkHeld("held_long", 1'b1);
    checkDrained("press_11");
    pressed = '0;
    step(9);
    checkHeld("release_before_8", 1'b1);
    step(1);
    checkHeld("release_after_8", 1'b0);
    step(20);
  endtask

  task automatic test_bounce;
    int guard;
    guard = 0;
    while (rowDrive !== 4'b0111 && guard < 40) begin
      step(1);
      guard++;
    end
    total++;
    if (rowDrive !== 4'b0111) begin
      bad++;
      $display("[TB] FAIL wait_row3 got %b, required 0111", rowDrive);
    end
    pressed[3*3+2] = 1'b1;
    step(5);
    pressed[3*3+2] = 1'b0;
    step(1);
    pressed[3*3+2] = 1'b1;
    step(5);
    pressed[3*3+2] = 1'b0;
    step(40);
    checkHeld("bounce_no_hold", 1'b0);
    pressed[3*3+2] = 1'b1;
    expectKey(3, 2);
    step(60);
    checkDrained("press_32");
    pressed = '0;
    step(30);
    checkHeld("release_32", 1'b0);
  endtask

  task automatic test_multi_key;
    pressed[2*3+0] = 1'b1;
    pressed[2*3+2] = 1'b1;
    expectKey(2, 0);
    step(60);
    checkDrained("priority_20");
    pressed[0*3+1] = 1'b1;
    step(100);
    checkHeld("rollover_held", 1'b1);
    pressed = '0;
    step(40);
    checkHeld("multi_release", 1'b0);
    checkDrained("no_rollover");
  endtask

  task automatic test_reset_in_wait;
    pressed[0*3+2] = 1'b1;
    expectKey(0, 2);
    step(60);
    checkHeld("held_02", 1'b1);
    checkDrained("press_02");
    #2 rst = 1'b1;
    #1;
    total++;
    if (rowDrive !== 4'b1110 || keyValid !== 1'b0 || keyHeld !== 1'b0 || RowOut !== 2'd0 || ColOut !== 2'd0) begin
      bad++;
      $display("[TB] FAIL async_reset got drive=%b valid=%b held=%b row=%0d col=%0d, required 1110 0 0 0 0",
               rowDrive, keyValid, keyHeld, RowOut, ColOut);
    end
    step(2);
    rst = 1'b0;
    expectKey(0, 2);
    step(60);
    checkDrained("redetect_02");
    pressed = '0;
    step(30);
    checkHeld("release_02", 1'b0);
  endtask

  task automatic test_release_glitch;
    pressed[1*3+2] = 1'b1;
    expectKey(1, 2);
    step(60);
    checkDrained("press_12");
    pressed = '0;
    step(7);
    pressed[1*3+2] = 1'b1;
    step(30);
    checkHeld("glitch_held", 1'b1);
    pressed = '0;
    step(30);
    checkHeld("glitch_release", 1'b0);
    checkDrained("glitch_no_extra");
  endtask

  initial begin
    total = 0;
    bad = 0;
    codeTable = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd14, 4'd0, 4'd15};
    test_reset();
    test_press_release();
    test_bounce();
    test_multi_key();
    test_reset_in_wait();
    test_release_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
